matmul_param_stream: RTL and testbench
======================================

MATMUL_PARAM_STREAM -- requirements
Module: matmul_param_stream

Interface
REQ-001 The block SHALL provide parameter N, default 4, matrix dimension (NxN, N>=2).
REQ-002 The block SHALL provide parameter DW, default 8, unsigned element width of A and B.
REQ-003 The block SHALL provide parameter OW, default 2*DW+$clog2(N), result element width.
REQ-004 The block SHALL provide port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL provide port reset, input, 1, reset, asynchronous, active-high.
REQ-006 The block SHALL provide port wr_en, input, 1, operand write strobe.
REQ-007 The block SHALL provide port wr_sel, input, 1, 0 selects A, 1 selects B.
REQ-008 The block SHALL provide port wr_addr, input, $clog2(N*N), row-major element index (row*N+col).
REQ-009 The block SHALL provide port wr_data, input, DW, operand element value.
REQ-010 The block SHALL provide port start, input, 1, launch C = A x B.
REQ-011 The block SHALL provide port busy, output, 1, high while computing.
REQ-012 The block SHALL provide port done, output, 1, single-cycle completion pulse.
REQ-013 The block SHALL provide port rd_addr, input, $clog2(N*N), row-major result index.
REQ-014 The block SHALL provide port rd_data, output, OW, registered C[rd_addr].

Function
REQ-015 States SHALL be IDLE, CALC and DONE; IDLE->CALC on start sampled high in IDLE; CALC->DONE after the last C write; DONE->IDLE unconditionally after one cycle.
REQ-016 In CALC, each C element SHALL take N MAC cycles (acc += A[i][k]*B[k][j], k=0..N-1) plus one write cycle that stores the result and clears acc; order i-major, then j.
REQ-017 The accumulator SHALL be 2*DW+$clog2(N) bits wide, so no internal overflow occurs.
REQ-018 done SHALL be high exactly in the DONE cycle; its rising edge SHALL occur N*N*(N+1)+1 clocks after the edge sampling start (81 for N=4).
REQ-019 busy SHALL be high in CALC and DONE and low in IDLE.
REQ-020 wr_en SHALL update A/B only in IDLE; writes while busy SHALL be discarded.
REQ-021 A write and start at the same IDLE edge SHALL both take effect, and the written value SHALL be used by the computation.
REQ-022 start while busy SHALL be ignored, with no queuing.
REQ-023 rd_data SHALL equal C[rd_addr] one clock after rd_addr is presented, in any state; reads during CALC return current (partially updated) contents.
REQ-024 A, B and C contents SHALL persist across computations; a new start SHALL reuse stored operands.

Reset
REQ-025 On reset, state SHALL go to IDLE, busy=0, done=0, rd_data=0, acc=0 and indices=0, including mid-CALC.
REQ-026 Reset SHALL NOT clear A, B or C storage; C contents after a mid-CALC reset are unspecified until the next completed run.

Configuration
REQ-027 With MATMUL_SAT_EN defined, a result exceeding 2^OW-1 SHALL be stored as 2^OW-1.
REQ-028 Without MATMUL_SAT_EN, the stored result SHALL be the low OW bits of the accumulator (wrap).
REQ-029 With the default OW, both configurations SHALL yield identical results.

Verification
REQ-030 N=4: A=1..16 row-major, B=identity, start -> done rises 81 clocks later; C reads 1..16; busy low one cycle after done.
REQ-031 N=4: all A,B=255 -> every C=260100 (18-bit); with OW=16: MATMUL_SAT_EN -> 65535, without -> 63492.
REQ-032 Pulse start at cycle 10 of CALC and write A[0]=99 -> no restart, done still at 81, A[0] unchanged, results match the original operands.
REQ-033 Assert reset at CALC cycle 20 -> busy=0, done=0, rd_data=0 next cycle; then start -> correct C and done after 81 clocks.
REQ-034 N=2, DW=4: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]], done after 13 clocks.
REQ-035 Same-edge write of B[0]=2 with start, B otherwise identity and A=1..16 -> C column 0 = 2,10,18,26 (doubled); other columns equal A.

Source files
------------

// File: rtl/matmul_param_stream_if.sv
// Operand-write / start / result-read bundle for matmul_param_stream.
// The master drives operands, start and rd_addr; the slave returns status and results.
interface matmul_param_stream_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 2 * DW + $clog2(N)
) ();
    localparam int unsigned AW = $clog2(N * N);

    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [OW-1:0] rd_data;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
        input  busy, done, rd_data
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
        output busy, done, rd_data
    );
endinterface

// File: rtl/matmul_param_stream.sv
// Sequential NxN unsigned matrix multiplier C = A x B, one MAC per clock.
// Define MATMUL_SAT_EN to saturate results to OW bits instead of wrapping.
module matmul_param_stream #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 2 * DW + $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    matmul_param_stream_if.slave  bus
);
    localparam int unsigned AW   = $clog2(N * N);
    localparam int unsigned IW   = $clog2(N);
    localparam int unsigned KW   = $clog2(N + 1);
    localparam int unsigned ACCW = 2 * DW + $clog2(N);
    localparam int unsigned LAST = N - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0] a_mem [N*N];
    logic [DW-1:0] b_mem [N*N];
    logic [OW-1:0] c_mem [N*N];

    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            fin_q, fin_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [OW-1:0]   rd_data_q;

    logic            c_we;
    logic [AW-1:0]   c_waddr;
    logic [OW-1:0]   c_wdata;
    logic [AW-1:0]   a_raddr;
    logic [AW-1:0]   b_raddr;

    // Reduce the accumulator to the stored result width.
    function automatic logic [OW-1:0] fit(input logic [ACCW-1:0] v);
`ifdef MATMUL_SAT_EN
        if (ACCW > OW && (v >> OW) != '0) begin
            fit = '1;
        end else begin
            fit = OW'(v);
        end
`else
        fit = OW'(v);
`endif
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: CALC ends the cycle after the last C write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (fin_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs, computed from the upcoming state and registered below.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // MAC sequencing: N accumulate cycles then one write-back per element, i-major.
    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        fin_d   = fin_q;
        c_we    = 1'b0;
        c_waddr = AW'(i_q) * AW'(N) + AW'(j_q);
        c_wdata = fit(acc_q);
        a_raddr = '0;
        b_raddr = '0;
        if (state_q == CALC && !fin_q) begin
            if (k_q != KW'(N)) begin
                a_raddr = AW'(i_q) * AW'(N) + AW'(k_q);
                b_raddr = AW'(k_q) * AW'(N) + AW'(j_q);
                acc_d   = acc_q + ACCW'(a_mem[a_raddr]) * ACCW'(b_mem[b_raddr]);
                k_d     = k_q + KW'(1);
            end else begin
                c_we  = 1'b1;
                acc_d = '0;
                k_d   = '0;
                if (j_q == IW'(LAST)) begin
                    j_d = '0;
                    if (i_q == IW'(LAST)) begin
                        i_d   = '0;
                        fin_d = 1'b1;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
        end else if (state_q != CALC) begin
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
            acc_d = '0;
            fin_d = 1'b0;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            fin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            fin_q     <= fin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= c_mem[bus.rd_addr];
        end
    end

    // Operand storage survives reset; writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state_q == IDLE) begin
            if (bus.wr_sel) begin
                b_mem[bus.wr_addr] <= bus.wr_data;
            end else begin
                a_mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (c_we) begin
            c_mem[c_waddr] <= c_wdata;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_matmul_param_stream.sv
// Directed bench for matmul_param_stream: default 4x4, a 4x4 OW=16 copy and a 2x2 DW=4 copy.
module tb_matmul_param_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    matmul_param_stream_if #(.N(4), .DW(8))           if4 ();
    matmul_param_stream_if #(.N(4), .DW(8), .OW(16))  if16 ();
    matmul_param_stream_if #(.N(2), .DW(4))           if2 ();

    matmul_param_stream #(.N(4), .DW(8))          u_dut4  (.clk(clk), .reset(reset), .bus(if4));
    matmul_param_stream #(.N(4), .DW(8), .OW(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));
    matmul_param_stream #(.N(2), .DW(4))          u_dut2  (.clk(clk), .reset(reset), .bus(if2));

    task automatic wr4(input logic sel, input int addr, input int data);
        if4.wr_en   = 1'b1;
        if4.wr_sel  = sel;
        if4.wr_addr = 4'(addr);
        if4.wr_data = 8'(data);
        @(negedge clk);
        if4.wr_en = 1'b0;
    endtask

    task automatic rd4(input int addr, output logic [31:0] val);
        if4.rd_addr = 4'(addr);
        @(negedge clk);
        val = 32'(if4.rd_data);
    endtask

    // Pulse start (plus any write already set up), then count clocks until done.
    task automatic go4(output int cyc);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        if4.wr_en = 1'b0;
        cyc = 0;
        while (if4.done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if4.busy); end
        checks++;
        if (if4.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", if4.done); end
        checks++;
        if (if4.rd_data !== 18'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", if4.rd_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int cyc;
        logic [31:0] v;
        for (int i = 0; i < 16; i++) wr4(1'b0, i, i + 1);
        for (int i = 0; i < 16; i++) wr4(1'b1, i, (i % 5 == 0) ? 1 : 0);
        go4(cyc);
        checks++;
        if (cyc !== 81) begin errors++; $display("FAIL ident_latency got %0d want 81", cyc); end
        checks++;
        if (if4.busy !== 1'b1) begin errors++; $display("FAIL ident_busy_at_done got %b want 1", if4.busy); end
        @(negedge clk);
        checks++;
        if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
            errors++; $display("FAIL ident_after_done got busy=%b done=%b want 0 0", if4.busy, if4.done);
        end
        for (int i = 0; i < 16; i++) begin
            rd4(i, v);
            checks++;
            if (v !== 32'(i + 1)) begin errors++; $display("FAIL ident_c[%0d] got %0d want %0d", i, v, i + 1); end
        end
    endtask

    task automatic test_same_edge();
        int cyc;
        int exp;
        logic [31:0] v;
        if4.wr_en   = 1'b1;
        if4.wr_sel  = 1'b1;
        if4.wr_addr = 4'd0;
        if4.wr_data = 8'd2;
        go4(cyc);
        checks++;
        if (cyc !== 81) begin errors++; $display("FAIL same_edge_latency got %0d want 81", cyc); end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp = (i % 4 == 0) ? 2 * (i + 1) : i + 1;
            rd4(i, v);
            checks++;
            if (v !== 32'(exp)) begin errors++; $display("FAIL same_edge_c[%0d] got %0d want %0d", i, v, exp); end
        end
        wr4(1'b1, 0, 1);
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic [31:0] v;
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        cyc = 0;
        while (if4.done !== 1'b1 && cyc < 300) begin
            if (cyc == 10) begin
                if4.start   = 1'b1;
                if4.wr_en   = 1'b1;
                if4.wr_sel  = 1'b0;
                if4.wr_addr = 4'd0;
                if4.wr_data = 8'd99;
            end
            @(negedge clk);
            cyc++;
            if4.start = 1'b0;
            if4.wr_en = 1'b0;
        end
        checks++;
        if (cyc !== 81) begin errors++; $display("FAIL busy_ign_latency got %0d want 81", cyc); end
        repeat (3) @(negedge clk);
        checks++;
        if (if4.busy !== 1'b0) begin errors++; $display("FAIL busy_ign_no_restart got busy=%b want 0", if4.busy); end
        for (int i = 0; i < 16; i++) begin
            rd4(i, v);
            checks++;
            if (v !== 32'(i + 1)) begin errors++; $display("FAIL busy_ign_c[%0d] got %0d want %0d", i, v, i + 1); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] v;
        for (int i = 0; i < 16; i += 5) wr4(1'b1, i, 2);
        if4.rd_addr = 4'd15;
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_status got busy=%b done=%b want 0 0", if4.busy, if4.done);
        end
        checks++;
        if (if4.rd_data !== 18'd0) begin errors++; $display("FAIL mid_reset_rd_data got %0d want 0", if4.rd_data); end
        reset = 1'b0;
        @(negedge clk);
        go4(cyc);
        checks++;
        if (cyc !== 81) begin errors++; $display("FAIL mid_reset_latency got %0d want 81", cyc); end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd4(i, v);
            checks++;
            if (v !== 32'(2 * (i + 1))) begin errors++; $display("FAIL mid_reset_c[%0d] got %0d want %0d", i, v, 2 * (i + 1)); end
        end
    endtask

    task automatic test_saturation();
        int cyc;
        int exp16;
        logic [31:0] v4;
        logic [31:0] v16;
`ifdef MATMUL_SAT_EN
        exp16 = 65535;
`else
        exp16 = 63492;
`endif
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                if4.wr_en = 1'b1;  if4.wr_sel = s[0];  if4.wr_addr = 4'(i);  if4.wr_data = 8'd255;
                if16.wr_en = 1'b1; if16.wr_sel = s[0]; if16.wr_addr = 4'(i); if16.wr_data = 8'd255;
                @(negedge clk);
            end
        end
        if4.wr_en = 1'b0;
        if16.wr_en = 1'b0;
        if4.start = 1'b1;
        if16.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        if16.start = 1'b0;
        cyc = 0;
        while (if4.done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 81 || if16.done !== 1'b1) begin
            errors++; $display("FAIL sat_latency got %0d done16=%b want 81 1", cyc, if16.done);
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if4.rd_addr = 4'(i);
            if16.rd_addr = 4'(i);
            @(negedge clk);
            v4 = 32'(if4.rd_data);
            v16 = 32'(if16.rd_data);
            checks++;
            if (v4 !== 32'd260100) begin errors++; $display("FAIL full_c[%0d] got %0d want 260100", i, v4); end
            checks++;
            if (v16 !== 32'(exp16)) begin errors++; $display("FAIL ow16_c[%0d] got %0d want %0d", i, v16, exp16); end
        end
    endtask

    task automatic test_small();
        int cyc;
        int a_v[4] = '{1, 2, 3, 4};
        int b_v[4] = '{5, 6, 7, 8};
        int c_v[4] = '{19, 22, 43, 50};
        logic [31:0] v;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                if2.wr_en = 1'b1;
                if2.wr_sel = s[0];
                if2.wr_addr = 2'(i);
                if2.wr_data = (s == 0) ? 4'(a_v[i]) : 4'(b_v[i]);
                @(negedge clk);
            end
        end
        if2.wr_en = 1'b0;
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        cyc = 0;
        while (if2.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 13) begin errors++; $display("FAIL small_latency got %0d want 13", cyc); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if2.rd_addr = 2'(i);
            @(negedge clk);
            v = 32'(if2.rd_data);
            checks++;
            if (v !== 32'(c_v[i])) begin errors++; $display("FAIL small_c[%0d] got %0d want %0d", i, v, c_v[i]); end
        end
    endtask

    initial begin
        if4.wr_en = 1'b0;  if4.wr_sel = 1'b0;  if4.wr_addr = '0;  if4.wr_data = '0;  if4.start = 1'b0;  if4.rd_addr = '0;
        if16.wr_en = 1'b0; if16.wr_sel = 1'b0; if16.wr_addr = '0; if16.wr_data = '0; if16.start = 1'b0; if16.rd_addr = '0;
        if2.wr_en = 1'b0;  if2.wr_sel = 1'b0;  if2.wr_addr = '0;  if2.wr_data = '0;  if2.start = 1'b0;  if2.rd_addr = '0;
        test_reset();
        test_identity();
        test_same_edge();
        test_busy_ignore();
        test_reset_mid();
        test_saturation();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
